// File: rtl/store_drain_pkg.sv
// Store drain buffer shared types: size encoding, lane masks, misalignment rule, entry layout.
// Pure declarations and combinational helpers; no latency, no flow control.
// Backpressure: not applicable.
package store_drain_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } store_size_e;

    localparam int SDB_ADDR_W = 64;
    localparam int SDB_DATA_W = 64;
    localparam int SDB_STRB_W = SDB_DATA_W / 8;
    localparam int SDB_LINE_W = SDB_ADDR_W - 3;

    typedef struct packed {
        logic [SDB_LINE_W-1:0] line;
        logic [SDB_DATA_W-1:0] data;
        logic [SDB_STRB_W-1:0] strb;
    } sdb_entry_t;

    function automatic logic [7:0] size_to_mask(store_size_e sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(store_size_e sz, logic [2:0] off);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    // Expands a byte-enable vector into a per-bit mask over the 8-byte lane.
    function automatic logic [63:0] strb_to_bits(logic [7:0] strb);
        logic [63:0] bits;
        for (int i = 0; i < 8; i++) begin
            bits[8*i +: 8] = {8{strb[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Places a right-aligned store value into its 8-byte lane and derives byte enables.
// Latency: purely combinational.
// Backpressure: none; reports misalignment for the caller to drop the store.
module store_lane_align
    import store_drain_pkg::*;
(
    input  logic [2:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic [63:0] i_data,
    output logic [63:0] o_data,
    output logic [7:0]  o_strb,
    output logic        o_misaligned
);

    store_size_e w_size;
    logic [7:0]  w_mask;

    assign w_size       = store_size_e'(i_size);
    assign w_mask       = size_to_mask(w_size);
    assign o_strb       = w_mask << i_off;
    assign o_data       = (i_data & strb_to_bits(w_mask)) << {i_off, 3'b000};
    assign o_misaligned = is_misaligned(w_size, i_off);

endmodule

// File: rtl/store_drain_buffer.sv
// In-order store queue draining to the data bus via req/ack; combinational line-hazard query.
// Latency: accept at N -> bus req at N+1; ack at N pops head, next head on bus at N+1.
// Backpressure: out_ready low when full (STORE_DRAIN_MERGE_EN: same-line tail merges still accepted).
module store_drain_buffer
    import store_drain_pkg::*;
#(
    parameter int ADDRESS_WIDTH = SDB_ADDR_W,
    parameter int DATA_WIDTH    = SDB_DATA_W,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [ADDRESS_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic [1:0]                 in_size,
    output logic                       out_ready,
    output logic                       out_bus_req,
    output logic [ADDRESS_WIDTH-1:0]   out_bus_addr,
    output logic [DATA_WIDTH-1:0]      out_bus_data,
    output logic [DATA_WIDTH/8-1:0]    out_bus_strb,
    input  logic                       in_bus_ack,
    input  logic [ADDRESS_WIDTH-1:0]   in_query_addr,
    output logic                       out_query_hit,
    output logic                       out_empty,
    output logic [$clog2(DEPTH+1)-1:0] out_count,
    output logic                       out_error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    sdb_entry_t              r_q [DEPTH];
    logic [DEPTH-1:0]        r_valid;
    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [CNT_W-1:0]        r_count;
    logic                    r_error;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_misaligned;
    logic [SDB_LINE_W-1:0]   w_line;
    logic                    w_full;
    logic                    w_merge_ok;
    logic                    w_acc;
    logic                    w_push;
    logic                    w_pop;
    logic [ADDRESS_WIDTH-1:0] w_query_line_addr;
    logic                    w_hit;

    store_lane_align u_align (
        .i_off        (in_addr[2:0]),
        .i_size       (in_size),
        .i_data       (in_data),
        .o_data       (w_data),
        .o_strb       (w_strb),
        .o_misaligned (w_misaligned)
    );

    assign w_line = in_addr[ADDRESS_WIDTH-1:3];
    assign w_full = (r_count == CNT_W'(DEPTH));

`ifdef STORE_DRAIN_MERGE_EN
    logic [PTR_W-1:0] w_last;
    assign w_last     = r_tail - PTR_W'(1);
    // Tail may only absorb a store while it is not the head being offered on the bus.
    assign w_merge_ok = (r_count >= CNT_W'(2)) && (r_q[w_last].line == w_line);
`else
    assign w_merge_ok = 1'b0;
`endif

    assign out_ready = !w_full || w_merge_ok;
    assign w_acc     = in_valid && out_ready && !w_misaligned;
    assign w_push    = w_acc && !w_merge_ok;
    assign w_pop     = (r_count != '0) && in_bus_ack;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_tail].line <= w_line;
            r_q[r_tail].data <= w_data;
            r_q[r_tail].strb <= w_strb;
        end
`ifdef STORE_DRAIN_MERGE_EN
        if (w_acc && w_merge_ok) begin
            r_q[w_last].strb <= r_q[w_last].strb | w_strb;
            r_q[w_last].data <= (r_q[w_last].data & ~strb_to_bits(w_strb)) | w_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            if (in_valid && w_misaligned) begin
                r_error <= 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign w_query_line_addr = in_query_addr & ~ADDRESS_WIDTH'(7);

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && ({r_q[i].line, 3'b000} == w_query_line_addr)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign out_query_hit = w_hit;
    assign out_bus_req   = (r_count != '0);
    assign out_bus_addr  = {r_q[r_head].line, 3'b000};
    assign out_bus_data  = r_q[r_head].data;
    assign out_bus_strb  = r_q[r_head].strb;
    assign out_empty     = (r_count == '0);
    assign out_count     = r_count;
    assign out_error     = r_error;

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed-vector bench for store_drain_buffer with hand-computed expectations.
module tb_store_drain_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_addr;
    logic [63:0] in_data;
    logic [1:0]  in_size;
    logic        out_ready;
    logic        out_bus_req;
    logic [63:0] out_bus_addr;
    logic [63:0] out_bus_data;
    logic [7:0]  out_bus_strb;
    logic        in_bus_ack;
    logic [63:0] in_query_addr;
    logic        out_query_hit;
    logic        out_empty;
    logic [2:0]  out_count;
    logic        out_error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    store_drain_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .in_size       (in_size),
        .out_ready     (out_ready),
        .out_bus_req   (out_bus_req),
        .out_bus_addr  (out_bus_addr),
        .out_bus_data  (out_bus_data),
        .out_bus_strb  (out_bus_strb),
        .in_bus_ack    (in_bus_ack),
        .in_query_addr (in_query_addr),
        .out_query_hit (out_query_hit),
        .out_empty     (out_empty),
        .out_count     (out_count),
        .out_error     (out_error)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_size  = sz;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_addr       = '0;
        in_data       = '0;
        in_size       = 2'd0;
        in_bus_ack    = 1'b0;
        in_query_addr = '0;
        step();
        step();
        reset = 1'b0;

        chk("rst_ready", out_ready, 1);
        chk("rst_req",   out_bus_req, 0);
        chk("rst_empty", out_empty, 1);
        chk("rst_count", out_count, 0);
        chk("rst_error", out_error, 0);
        chk("rst_hit",   out_query_hit, 0);

        // sw into the upper half of a line
        offer(64'h1004, 64'hDEADBEEF, 2'd2);
        chk("sw_req",  out_bus_req, 1);
        chk("sw_addr", out_bus_addr, 64'h1000);
        chk("sw_data", out_bus_data, 64'hDEADBEEF_00000000);
        chk("sw_strb", out_bus_strb, 8'hF0);
        in_bus_ack = 1'b1;
        step();
        in_bus_ack = 1'b0;
        chk("sw_empty", out_empty, 1);
        chk("sw_req_lo", out_bus_req, 0);

        // fill to capacity, drop the overflow push, then drain in order
        for (int i = 0; i < 4; i++) begin
            offer(64'h100 + 64'(8*i), 64'(i + 1), 2'd3);
        end
        chk("full_ready", out_ready, 0);
        chk("full_count", out_count, 4);
        offer(64'h120, 64'h55, 2'd3);
        chk("ovf_count", out_count, 4);
        in_query_addr = 64'h120;
        #1;
        chk("ovf_hit", out_query_hit, 0);
        in_bus_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_req%0d", i),  out_bus_req, 1);
            chk($sformatf("drain_addr%0d", i), out_bus_addr, 64'h100 + 64'(8*i));
            chk($sformatf("drain_data%0d", i), out_bus_data, 64'(i + 1));
            step();
        end
        in_bus_ack = 1'b0;
        chk("drain_count", out_count, 0);
        chk("drain_empty", out_empty, 1);

        // hazard query against a pending store
        offer(64'h2000, 64'h1234, 2'd3);
        in_query_addr = 64'h2006;
        #1;
        chk("q_hit_same", out_query_hit, 1);
        in_query_addr = 64'h2008;
        #1;
        chk("q_hit_next", out_query_hit, 0);
        in_query_addr = 64'h2006;
        in_bus_ack    = 1'b1;
        step();
        in_bus_ack = 1'b0;
        chk("q_hit_acked", out_query_hit, 0);

        // misaligned halfword is dropped, error sticks until reset
        offer(64'h1003, 64'hBEEF, 2'd1);
        chk("mis_count", out_count, 0);
        chk("mis_error", out_error, 1);
        chk("mis_ready", out_ready, 1);
        offer(64'h40, 64'h7, 2'd0);
        chk("mis_after_count", out_count, 1);
        chk("mis_after_strb", out_bus_strb, 8'h01);
        in_bus_ack = 1'b1;
        step();
        in_bus_ack = 1'b0;
        chk("mis_sticky", out_error, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mis_cleared", out_error, 0);

        // byte stores to one line behind a stalled head
        offer(64'h5000, 64'hCAFE, 2'd3);
        offer(64'h3000, 64'hFFFF_FFFF_FFFF_FFAA, 2'd0);
        offer(64'h3001, 64'h1234_5678_9ABC_DEBB, 2'd0);
`ifdef STORE_DRAIN_MERGE_EN
        chk("merge_count", out_count, 2);
`else
        chk("merge_count", out_count, 3);
`endif
        in_bus_ack = 1'b1;
        step();
        in_bus_ack = 1'b0;
        chk("merge_head_addr", out_bus_addr, 64'h3000);
`ifdef STORE_DRAIN_MERGE_EN
        chk("merge_head_strb", out_bus_strb, 8'h03);
        chk("merge_head_data", out_bus_data, 64'hBBAA);
`else
        chk("merge_head_strb", out_bus_strb, 8'h01);
        chk("merge_head_data", out_bus_data, 64'hAA);
`endif

        // reset while a request is outstanding abandons it
        chk("mid_req_before", out_bus_req, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_req_after", out_bus_req, 0);
        chk("mid_count", out_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
